dsp_mac_pipelined: RTL
======================

Name: dsp_mac_pipelined

Overview:
- Parametrised, pipelined multiply-add/accumulate block intended to map onto a single hard DSP slice.
- Generalises the combinational product-plus-shifted-addend pattern in four ways:
  - configurable operand widths and addend shift;
  - configurable pipeline depth;
  - signed/unsigned arithmetic;
  - add/subtract/accumulate modes with valid/ready flow control.
- Sits between operand producers and downstream consumers in the DSP-template test designs.

Parameters:
- A_W, 17, width of multiplicand a
- B_W, 17, width of multiplier b
- C_W, 32, width of raw addend c
- C_SHIFT, 17, right-shift amount applied to c
- C_KEEP, 17, low bits of shifted c retained, then extended
- ACC_W, 48, internal accumulator/product width (must be >= A_W+B_W and >= C_KEEP)
- OUT_W, 32, result width
- PIPE_DEPTH, 2, register stages from input acceptance to output, legal range 1..4

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  A_W  multiplicand
- b  in  B_W  multiplier
- c  in  C_W  addend source
- op  in  2  0=ADD, 1=SUB, 2=ACC, 3=LOAD
- signed_mode  in  1  1 = treat a, b, c as two's complement
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out  out  OUT_W  result

Behaviour:
- Reset: asynchronous on rst_n low. Clears all stage valid bits, out_valid=0, out=0, accumulator=0. In-flight beats are discarded, not completed. First acceptance possible in the first clk edge after rst_n rises.
- Flow control: global advance enable en = !out_valid || out_ready; in_ready = en.
  - Beat accepted when in_valid && in_ready.
  - When en=0, every stage register holds, including out/out_valid. No beat is lost or duplicated.
  - Bubbles propagate as stage valid=0.
- Latency: exactly PIPE_DEPTH advancing cycles from acceptance to out_valid. Throughput 1 beat/cycle when out_ready stays high. Results emerge in acceptance order.
- Arithmetic:
  - prod = a*b at ACC_W bits; sign-extended operands if signed_mode, else zero-extended.
  - cterm = (c shifted right by C_SHIFT, arithmetic if signed_mode, else logical), low C_KEEP bits, then sign-extended (signed_mode) or zero-extended to ACC_W.
  - signed_mode and op are captured with the beat and travel with it.
- Ops, all at ACC_W, wrapping modulo 2^ACC_W:
  - ADD: r = prod + cterm.
  - SUB: r = prod - cterm.
  - ACC: r = acc + prod; acc <= r. cterm is ignored.
  - LOAD: r = prod + cterm; acc <= r.
- Accumulator:
  - acc updates only in the final stage, only for ACC/LOAD beats, only when en=1. Back-to-back ACC beats therefore chain correctly with no hazard.
  - ADD/SUB never modify acc.
- out = r[OUT_W-1:0], i.e. truncated, registered in the final stage.

Optional Feature:
- Macro: DSP_MAC_SAT_EN
- Defined: out is r clamped to the OUT_W range instead of truncated.
  - signed_mode=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - signed_mode=0: clamp to [0, 2^OUT_W-1]; negative r from SUB gives 0.
  - acc itself still wraps at ACC_W.
- Undefined: plain truncation. No saturation logic is synthesised.

Test Plan:
- Defaults, signed, ADD, a=3, b=5, c=32'h0006_0000 (cterm=3), out_ready=1 -> out=18 with out_valid exactly 2 cycles after acceptance.
- Unsigned, ADD, a=b=131071, c=0 -> out=32'hFFFC_0001 (truncated). With DSP_MAC_SAT_EN -> 32'hFFFF_FFFF.
- Signed, c=32'hFFFE_0000 (cterm=-1), a=2, b=2: ADD -> 3; SUB -> 5.
- Back-to-back, no gaps: LOAD(1,1,c=0), ACC(4,4), ACC(-2,3 signed) -> outputs 1, 17, 11 on consecutive cycles. A following ADD(1,1,0) -> 1, and acc remains 11.
- Stall: two beats in flight, out_ready=0 for 3 cycles -> in_ready=0, out/out_valid held stable. Release -> both results delivered in order, none duplicated.
- Reset: assert rst_n=0 mid-stream with 2 beats in flight and acc=11 -> out_valid=0, out=0 immediately. After release, ACC(1,1) -> 1.

Source files
------------

// File: rtl/dsp_mac_pipelined.sv
// Pipelined multiply-add/accumulate with valid/ready flow control, sized for one DSP slice.
// Define DSP_MAC_SAT_EN to clamp the result to the OUT_W range instead of truncating it.
module dsp_mac_pipelined #(
    parameter int A_W        = 17,
    parameter int B_W        = 17,
    parameter int C_W        = 32,
    parameter int C_SHIFT    = 17,
    parameter int C_KEEP     = 17,
    parameter int ACC_W      = 48,
    parameter int OUT_W      = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    input  logic [1:0]       op,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out
);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_ACC  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    // Valid/ready: a beat moves when valid && ready; every stage advances together on w_en.
`ifdef DSP_MAC_SAT_EN
    localparam int CTL_W = 3;
`else
    localparam int CTL_W = 2;
`endif

    logic             w_en;
    logic [CTL_W-1:0] w_ctl;
    logic [ACC_W-1:0] w_a_ext;
    logic [ACC_W-1:0] w_b_ext;
    logic [ACC_W-1:0] w_prod;
    logic [C_KEEP-1:0] w_c_keep;
    logic [ACC_W-1:0] w_cterm;

    logic             w_f_valid;
    logic [CTL_W-1:0] w_f_ctl;
    logic [ACC_W-1:0] w_f_prod;
    logic [ACC_W-1:0] w_f_cterm;

    logic [ACC_W-1:0] w_res;
    logic             w_acc_wr;
    logic [OUT_W-1:0] w_out_val;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out;
    logic [ACC_W-1:0] r_acc;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

`ifdef DSP_MAC_SAT_EN
    assign w_ctl = {signed_mode, op};
`else
    assign w_ctl = op;
`endif

    always_comb begin
        w_a_ext  = {{(ACC_W-A_W){signed_mode & a[A_W-1]}}, a};
        w_b_ext  = {{(ACC_W-B_W){signed_mode & b[B_W-1]}}, b};
        w_prod   = w_a_ext * w_b_ext;
        w_c_keep = signed_mode ? C_KEEP'($signed(c) >>> C_SHIFT) : C_KEEP'(c >> C_SHIFT);
        w_cterm  = {{(ACC_W-C_KEEP){signed_mode & w_c_keep[C_KEEP-1]}}, w_c_keep};
    end

    // The first PIPE_DEPTH-1 stages carry product and addend; the last stage owns acc and out.
    generate
        if (PIPE_DEPTH > 1) begin : g_pipe
            localparam int N = PIPE_DEPTH - 1;
            logic             r_v     [N];
            logic [CTL_W-1:0] r_ctl   [N];
            logic [ACC_W-1:0] r_prod  [N];
            logic [ACC_W-1:0] r_cterm [N];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < N; i++) begin
                        r_v[i]     <= 1'b0;
                        r_ctl[i]   <= '0;
                        r_prod[i]  <= '0;
                        r_cterm[i] <= '0;
                    end
                end else if (w_en) begin
                    r_v[0]     <= in_valid;
                    r_ctl[0]   <= w_ctl;
                    r_prod[0]  <= w_prod;
                    r_cterm[0] <= w_cterm;
                    for (int i = 1; i < N; i++) begin
                        r_v[i]     <= r_v[i-1];
                        r_ctl[i]   <= r_ctl[i-1];
                        r_prod[i]  <= r_prod[i-1];
                        r_cterm[i] <= r_cterm[i-1];
                    end
                end
            end

            assign w_f_valid = r_v[N-1];
            assign w_f_ctl   = r_ctl[N-1];
            assign w_f_prod  = r_prod[N-1];
            assign w_f_cterm = r_cterm[N-1];
        end else begin : g_comb
            assign w_f_valid = in_valid;
            assign w_f_ctl   = w_ctl;
            assign w_f_prod  = w_prod;
            assign w_f_cterm = w_cterm;
        end
    endgenerate

    always_comb begin
        w_res    = w_f_prod + w_f_cterm;
        w_acc_wr = 1'b0;
        case (w_f_ctl[1:0])
            OP_ADD:  w_res = w_f_prod + w_f_cterm;
            OP_SUB:  w_res = w_f_prod - w_f_cterm;
            OP_ACC: begin
                w_res    = r_acc + w_f_prod;
                w_acc_wr = 1'b1;
            end
            OP_LOAD: begin
                w_res    = w_f_prod + w_f_cterm;
                w_acc_wr = 1'b1;
            end
            default: w_res = w_f_prod + w_f_cterm;
        endcase
    end

`ifdef DSP_MAC_SAT_EN
    localparam logic [ACC_W-1:0] L_SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] L_SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] L_UMAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // Unsigned beats still read r as two's complement so an underflowing SUB clamps to 0.
    always_comb begin
        w_out_val = w_res[OUT_W-1:0];
        if (w_f_ctl[2]) begin
            if ($signed(w_res) > $signed(L_SMAX))
                w_out_val = {1'b0, {(OUT_W-1){1'b1}}};
            else if ($signed(w_res) < $signed(L_SMIN))
                w_out_val = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            if (w_res[ACC_W-1])
                w_out_val = '0;
            else if (w_res > L_UMAX)
                w_out_val = '1;
        end
    end
`else
    assign w_out_val = w_res[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_acc       <= '0;
        end else if (w_en) begin
            r_out_valid <= w_f_valid;
            if (w_f_valid) begin
                r_out <= w_out_val;
                if (w_acc_wr)
                    r_acc <= w_res;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule
